// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core control blocks:
// the run-controller state encoding and the display source selections.
package mips_pkg;

    // Execution states of the run controller.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        PAUSE = 3'd3,
        HALT  = 3'd4
    } run_state_t;

    // Display source selections on the disp_sel switches.
    localparam logic [2:0] DISP_CYC      = 3'd0;
    localparam logic [2:0] DISP_UNCOND   = 3'd1;
    localparam logic [2:0] DISP_COND     = 3'd2;
    localparam logic [2:0] DISP_COND_SUC = 3'd3;
    localparam logic [2:0] DISP_SYS      = 3'd4;
    localparam logic [2:0] DISP_ROT      = 3'd7;

    // Highest index visited by the auto-rotate sequence.
    localparam logic [2:0] ROT_LAST_IDX  = DISP_SYS;

    // The datapath is only allowed to advance in these two states.
    function automatic logic state_enables_cpu(input run_state_t s);
        return (s == RUN) || (s == STEP);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous button level followed by a
// third flop, producing a single-cycle pulse on each rising edge.
// No debouncing is done here; the board wrapper handles that.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Shift the raw level down the synchronizer chain.
    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer and edge-detect flops, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign pulse = s2_q & ~s3_q;

endmodule

// File: rtl/run_ctrl.sv
// Execution controller for the single-cycle MIPS core. Sequences
// RUN / STEP / PAUSE / HALT from the go button and the syscall halt
// request, and schedules which statistic counter drives the display,
// including an auto-rotate mode that cycles through all five counters.
module run_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned ROT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        step_mode,
    input  logic        halt_req,
    input  logic [2:0]  disp_sel,
    input  logic [31:0] stat_cyc,
    input  logic [31:0] stat_uncond,
    input  logic [31:0] stat_cond,
    input  logic [31:0] stat_cond_suc,
    input  logic [31:0] stat_sys,
    output logic        cpu_en,
    output logic        halted,
    output logic [31:0] disp_value,
    output logic [2:0]  disp_idx
);

    localparam logic [31:0] ROT_LAST = 32'(ROT_CYCLES - 1);

    logic go_pulse;

    run_state_t  state_q, state_d;
    logic        cpu_en_q, cpu_en_d;
    logic        halted_q, halted_d;

    logic [31:0] rot_cnt_q, rot_cnt_d;
    logic [2:0]  rot_idx_q, rot_idx_d;
    logic        rot_active_q, rot_active_d;
    logic [31:0] disp_value_q, disp_value_d;
    logic [2:0]  disp_idx_q, disp_idx_d;

    edge_sync u_go_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (go),
        .pulse    (go_pulse)
    );

    // Pick one statistic by display index; unused indices show zero.
    function automatic logic [31:0] pick_stat(
        input logic [2:0]  idx,
        input logic [31:0] s_cyc,
        input logic [31:0] s_uncond,
        input logic [31:0] s_cond,
        input logic [31:0] s_cond_suc,
        input logic [31:0] s_sys
    );
        logic [31:0] v;
        case (idx)
            DISP_CYC:      v = s_cyc;
            DISP_UNCOND:   v = s_uncond;
            DISP_COND:     v = s_cond;
            DISP_COND_SUC: v = s_cond_suc;
            DISP_SYS:      v = s_sys;
            default:       v = 32'd0;
        endcase
        return v;
    endfunction

    // Next-state rules; halt_req wins over everything in the enabled
    // states, and go_pulse is only honoured while the core is stopped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, PAUSE, HALT: begin
                if (go_pulse) begin
                    state_d = step_mode ? STEP : RUN;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (step_mode) begin
                    state_d = PAUSE;
                end
            end
            STEP: begin
                state_d = halt_req ? HALT : PAUSE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cpu_en_d = state_enables_cpu(state_d);
        halted_d = (state_d == HALT);
    end

    // FSM register with Moore outputs decoded from the next state so that
    // cpu_en and halted come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cpu_en_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpu_en_q <= cpu_en_d;
            halted_q <= halted_d;
        end
    end

    // Display scheduler: fixed selection passes the chosen counter through;
    // rotate mode restarts at index 0 on entry and advances the index each
    // time the dwell counter wraps, always showing the live counter value.
    always_comb begin
        rot_cnt_d    = 32'd0;
        rot_idx_d    = 3'd0;
        rot_active_d = (disp_sel == DISP_ROT);
        disp_idx_d   = 3'd0;
        disp_value_d = 32'd0;
        if (disp_sel == DISP_ROT) begin
            if (!rot_active_q) begin
                rot_cnt_d = 32'd0;
                rot_idx_d = 3'd0;
            end else if (rot_cnt_q == ROT_LAST) begin
                rot_cnt_d = 32'd0;
                rot_idx_d = (rot_idx_q == ROT_LAST_IDX) ? 3'd0 : rot_idx_q + 3'd1;
            end else begin
                rot_cnt_d = rot_cnt_q + 32'd1;
                rot_idx_d = rot_idx_q;
            end
            disp_idx_d   = rot_idx_d;
            disp_value_d = pick_stat(rot_idx_d, stat_cyc, stat_uncond, stat_cond,
                                     stat_cond_suc, stat_sys);
        end else if (disp_sel <= DISP_SYS) begin
            disp_idx_d   = disp_sel;
            disp_value_d = pick_stat(disp_sel, stat_cyc, stat_uncond, stat_cond,
                                     stat_cond_suc, stat_sys);
        end
    end

    // Display registers, cleared by reset so rotation restarts afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            rot_cnt_q    <= 32'd0;
            rot_idx_q    <= 3'd0;
            rot_active_q <= 1'b0;
            disp_idx_q   <= 3'd0;
            disp_value_q <= 32'd0;
        end else begin
            rot_cnt_q    <= rot_cnt_d;
            rot_idx_q    <= rot_idx_d;
            rot_active_q <= rot_active_d;
            disp_idx_q   <= disp_idx_d;
            disp_value_q <= disp_value_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign halted     = halted_q;
    assign disp_value = disp_value_q;
    assign disp_idx   = disp_idx_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a behavioural
// model of the controller and display scheduler.
module tb_run_ctrl;

    localparam int ROT = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_PAUSE = 3;
    localparam int M_HALT  = 4;

    logic        clk;
    logic        rst;
    logic        go;
    logic        step_mode;
    logic        halt_req;
    logic [2:0]  disp_sel;
    logic [31:0] stat [5];
    logic        cpu_en;
    logic        halted;
    logic [31:0] disp_value;
    logic [2:0]  disp_idx;

    int checks = 0;
    int errors = 0;

    int  m_state;
    bit  go_m1, go_m2, go_m3;
    int  rot_age;
    bit  was_rot;
    bit  hold_stats;
    bit  idx_checked;

    logic        exp_cpu_en;
    logic        exp_halted;
    logic [31:0] exp_value;
    logic [2:0]  exp_idx;

    int en_count;
    bit prev_en;
    bit adjacent;

    run_ctrl #(.ROT_CYCLES(ROT)) dut (
        .clk           (clk),
        .rst           (rst),
        .go            (go),
        .step_mode     (step_mode),
        .halt_req      (halt_req),
        .disp_sel      (disp_sel),
        .stat_cyc      (stat[0]),
        .stat_uncond   (stat[1]),
        .stat_cond     (stat[2]),
        .stat_cond_suc (stat[3]),
        .stat_sys      (stat[4]),
        .cpu_en        (cpu_en),
        .halted        (halted),
        .disp_value    (disp_value),
        .disp_idx      (disp_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model advanced once per clock edge with the inputs the
    // DUT sampled at that edge.
    task automatic modelEdge();
        bit pulse;
        bit enabled;
        pulse = go_m2 && !go_m3;
        enabled = (m_state == M_RUN) || (m_state == M_STEP);
        if (rst) begin
            m_state = M_IDLE;
        end else if (!enabled && pulse) begin
            m_state = step_mode ? M_STEP : M_RUN;
        end else if (enabled && halt_req) begin
            m_state = M_HALT;
        end else if (m_state == M_STEP) begin
            m_state = M_PAUSE;
        end else if (m_state == M_RUN && step_mode) begin
            m_state = M_PAUSE;
        end
        if (rst) begin
            go_m1 = 0; go_m2 = 0; go_m3 = 0;
        end else begin
            go_m3 = go_m2; go_m2 = go_m1; go_m1 = go;
        end
        exp_cpu_en = (m_state == M_RUN) || (m_state == M_STEP);
        exp_halted = (m_state == M_HALT);

        idx_checked = 1;
        if (rst) begin
            was_rot   = 0;
            rot_age   = 0;
            exp_idx   = 3'd0;
            exp_value = 32'd0;
        end else if (disp_sel == 3'd7) begin
            rot_age   = was_rot ? rot_age + 1 : 0;
            was_rot   = 1;
            exp_idx   = 3'((rot_age / ROT) % 5);
            exp_value = stat[exp_idx];
        end else begin
            was_rot = 0;
            if (disp_sel < 3'd5) begin
                exp_value   = stat[disp_sel];
                idx_checked = 0;
            end else begin
                exp_value = 32'd0;
                exp_idx   = 3'd0;
            end
        end
    endtask

    task automatic checkOutput();
        check("cpu_en", 32'(cpu_en), 32'(exp_cpu_en));
        check("halted", 32'(halted), 32'(exp_halted));
        check("disp_value", disp_value, exp_value);
        if (idx_checked) check("disp_idx", 32'(disp_idx), 32'(exp_idx));
    endtask

    task automatic applyStimulus(input bit r, input bit g, input bit sm, input bit hr,
                                 input logic [2:0] sel);
        rst       = r;
        go        = g;
        step_mode = sm;
        halt_req  = hr;
        disp_sel  = sel;
        if (!hold_stats) begin
            for (int i = 0; i < 5; i++) stat[i] = $urandom();
        end
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        m_state = M_IDLE;
        go_m1 = 0; go_m2 = 0; go_m3 = 0;
        rot_age = 0; was_rot = 0; hold_stats = 0;
        rst = 1; go = 0; step_mode = 0; halt_req = 0; disp_sel = 3'd0;
        for (int i = 0; i < 5; i++) stat[i] = 32'd0;

        // Reset
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 3'd0);
        check("reset_cpu_en", 32'(cpu_en), 32'd0);
        check("reset_disp_value", disp_value, 32'd0);
        applyStimulus(0, 0, 0, 0, 3'd0);
        applyStimulus(0, 0, 0, 0, 3'd0);

        // go held 5 cycles in free-run mode
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0, 3'd0);
            if (i == 1) check("go_latency_early", 32'(cpu_en), 32'd0);
            if (i == 2) check("go_latency", 32'(cpu_en), 32'd1);
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 3'd1);
        check("run_after_release", 32'(cpu_en), 32'd1);

        // Single-cycle halt request
        check("halt_cycle_enabled", 32'(cpu_en), 32'd1);
        applyStimulus(0, 0, 0, 1, 3'd0);
        check("halt_cpu_en", 32'(cpu_en), 32'd0);
        check("halt_flag", 32'(halted), 32'd1);
        applyStimulus(0, 0, 0, 0, 3'd0);
        check("halt_stays", 32'(halted), 32'd1);

        // Resume from HALT
        applyStimulus(0, 1, 0, 0, 3'd0);
        applyStimulus(0, 0, 0, 0, 3'd0);
        applyStimulus(0, 0, 0, 0, 3'd0);
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_cpu_en", 32'(cpu_en), 32'd1);

        // step_mode flipped while running
        applyStimulus(0, 0, 1, 0, 3'd0);
        check("run_to_pause", 32'(cpu_en), 32'd0);

        // Three single-step presses
        en_count = 0; prev_en = 0; adjacent = 0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 5; c++) begin
                applyStimulus(0, (c == 0), 1, 0, 3'd3);
                if (cpu_en) begin
                    en_count++;
                    if (prev_en) adjacent = 1;
                end
                prev_en = cpu_en;
            end
        end
        check("step_count", 32'(en_count), 32'd3);
        check("step_adjacent", 32'(adjacent), 32'd0);

        // Back to RUN, then go_pulse and halt_req in the same cycle
        applyStimulus(0, 1, 0, 0, 3'd0);
        applyStimulus(0, 0, 0, 0, 3'd0);
        applyStimulus(0, 0, 0, 0, 3'd0);
        check("rerun", 32'(cpu_en), 32'd1);
        applyStimulus(0, 1, 0, 0, 3'd0);
        applyStimulus(0, 0, 0, 0, 3'd0);
        applyStimulus(0, 0, 0, 1, 3'd0);
        check("halt_over_go", 32'(halted), 32'd1);
        applyStimulus(0, 0, 0, 0, 3'd0);
        check("halt_over_go_hold", 32'(halted), 32'd1);

        // Fixed display selections
        hold_stats = 1;
        stat[2] = 32'h1234;
        applyStimulus(0, 0, 0, 0, 3'd2);
        check("disp_cond", disp_value, 32'h1234);
        applyStimulus(0, 0, 0, 0, 3'd5);
        check("disp_sel5_value", disp_value, 32'd0);
        check("disp_sel5_idx", 32'(disp_idx), 32'd0);
        hold_stats = 0;

        // Auto-rotate, reset mid-rotation, then rotate again
        for (int i = 0; i < 45; i++) begin
            applyStimulus(0, 0, 0, 0, 3'd7);
            if (i == 3)  check("rot_idx_hold0", 32'(disp_idx), 32'd0);
            if (i == 4)  check("rot_idx_step1", 32'(disp_idx), 32'd1);
            if (i == 19) check("rot_idx_last", 32'(disp_idx), 32'd4);
            if (i == 20) check("rot_idx_wrap", 32'(disp_idx), 32'd0);
        end
        applyStimulus(1, 0, 0, 0, 3'd7);
        check("rot_reset_idx", 32'(disp_idx), 32'd0);
        check("rot_reset_value", disp_value, 32'd0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 3'd7);

        // Randomized phase
        begin
            bit r_go, r_sm, r_hr, r_rst;
            logic [2:0] r_sel;
            r_go = 0; r_sm = 0; r_sel = 3'd7;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 5) == 0)  r_go = ~r_go;
                if ($urandom_range(0, 30) == 0) r_sm = ~r_sm;
                if ($urandom_range(0, 25) == 0) r_sel = 3'($urandom_range(0, 7));
                r_hr  = ($urandom_range(0, 9) == 0);
                r_rst = ($urandom_range(0, 150) == 0);
                applyStimulus(r_rst, r_go, r_sm, r_hr, r_sel);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
